broadcast_load_checker: RTL and testbench

- Receiving-end checker for a single driver net fanned out to NCOPY loads across hierarchy, including feedthrough paths.
- Each load copy is one bit of `copies`. `ref_in` is the driver-side value, retimed to the same cycle as the copies.
- The block registers all copies, compares each against the reference, counts mismatches and reference activity, and latches the first failing copy index.
- Used as the observation end of buffer-insertion test designs, so that post-buffering equivalence is checkable in simulation.

---
 rtl/broadcast_load_checker.sv | 179 +++++++++++++++++
 tb/tb_broadcast_load_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/broadcast_load_checker.sv
// broadcast_load_checker
// ----------------------
// Receiving-end checker for one driver net that fans out to NCOPY loads,
// including loads reached through feedthrough paths. Each load copy arrives
// as one bit of `copies`. `ref_in` is the driver-side value, retimed so that
// it lines up with the copies in the same cycle.
//
// All copies and the reference are registered once. Each registered copy is
// then compared against the registered reference. After enable, a short
// settle window suppresses comparisons while the buffered paths fill.
// During checking the block counts cycles that have any mismatching copy and
// counts reference transitions. It also latches the lowest failing copy index
// of the first error.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset (overrides en and clr)
//   en            in   enable checking; low returns the FSM to IDLE
//   clr           in   synchronous clear of counters, sticky flag and index
//   ref_in        in   driver reference value
//   copies        in   [NCOPY] load-side copies, bit i = copy i
//   match         out  last compared cycle had every copy equal to ref
//   mismatch_cnt  out  [CNT_W] cycles with >=1 mismatching copy, saturating
//   toggle_cnt    out  [CNT_W] reference transitions seen while checking, saturating
//   err_sticky    out  set on the first mismatch
//   first_bad_idx out  [IDX_W] lowest mismatching copy index of the first error
//   busy          out  FSM is settling or checking

module broadcast_load_checker #(
  parameter int NCOPY  = 4,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2,
  parameter int IDX_W  = (NCOPY > 1) ? $clog2(NCOPY) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ref_in,
  input  logic [NCOPY-1:0] copies,
  output logic             match,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             err_sticky,
  output logic [IDX_W-1:0] first_bad_idx,
  output logic             busy
);

  // The settle counter only has to hold SETTLE-1, so size it to fit that value.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [SET_W-1:0] settle_nxt;

  logic [NCOPY-1:0] copies_q;
  logic             ref_q;
  logic             ref_qq;
  logic [NCOPY-1:0] bad;
  logic [IDX_W-1:0] low_idx;
  logic             do_check;

  // The capture stage runs every cycle, whatever the FSM state is. This keeps
  // the copies and the reference aligned with each other. ref_qq holds the
  // previous reference value, so a transition can be seen when ref_q changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      copies_q <= '0;
      ref_q    <= 1'b0;
      ref_qq   <= 1'b0;
    end else begin
      copies_q <= copies;
      ref_q    <= ref_in;
      ref_qq   <= ref_q;
    end
  end

  // The state register also holds the settle countdown. The countdown moves
  // together with the state, so the next-state logic updates both of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Next-state logic. Dropping en sends the FSM back to IDLE from any state.
  // Every new enable therefore passes through SETTLE again. SETTLE stays for
  // SETTLE edges in total before CHECK starts.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state_nxt = ST_CHECK;
          end else begin
            settle_nxt = settle_cnt - SET_W'(1);
          end
        end
        ST_CHECK: state_nxt = ST_CHECK;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic. A compare only takes effect when the FSM is in CHECK and en
  // is still high. On the edge where en falls, the counters hold and match
  // clears, just as if the FSM had already left CHECK.
  always_comb begin
    busy     = (state != ST_IDLE);
    do_check = (state == ST_CHECK) && en;
  end

  // Per-copy disagreement with the reference. The scan runs from the top bit
  // down, so the last hit it records is the lowest failing copy index.
  always_comb begin
    bad     = copies_q ^ {NCOPY{ref_q}};
    low_idx = '0;
    for (int i = NCOPY - 1; i >= 0; i--) begin
      if (bad[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // Checking results. clr wipes the accumulated history, and a mismatch or
  // toggle in the same cycle is discarded. clr leaves match alone, because
  // match describes only the most recent comparison. The counters stop at
  // all-ones instead of wrapping. The index is captured only on the error
  // that sets the sticky flag, so later errors never overwrite it.
  always_ff @(posedge clk) begin
    if (rst) begin
      match         <= 1'b0;
      mismatch_cnt  <= '0;
      toggle_cnt    <= '0;
      err_sticky    <= 1'b0;
      first_bad_idx <= '0;
    end else begin
      match <= do_check && (bad == '0);
      if (clr) begin
        mismatch_cnt  <= '0;
        toggle_cnt    <= '0;
        err_sticky    <= 1'b0;
        first_bad_idx <= '0;
      end else if (do_check) begin
        if ((bad != '0) && (mismatch_cnt != '1)) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
        if ((bad != '0) && !err_sticky) begin
          err_sticky    <= 1'b1;
          first_bad_idx <= low_idx;
        end
        if ((ref_q != ref_qq) && (toggle_cnt != '1)) begin
          toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_broadcast_load_checker.sv
// tb_broadcast_load_checker
// -------------------------
// Self-checking bench for broadcast_load_checker with the default parameters.
// A behavioural model is kept inside the bench. It tracks how many
// consecutive edges en has been high, and compares only once the settle
// window has passed. A compare process checks every DUT output against the
// model on each falling edge. Directed scenarios pin the model with
// hand-computed literal values. A long randomized run follows.
//
// Ports of the DUT are all driven or observed here; there are no ports on
// the bench itself.

module tb_broadcast_load_checker;

  localparam int NCOPY   = 4;
  localparam int CNT_W   = 8;
  localparam int SETTLE  = 2;
  localparam int IDX_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int ALL     = (1 << NCOPY) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clr;
  logic             ref_in;
  logic [NCOPY-1:0] copies;
  logic             match;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] toggle_cnt;
  logic             err_sticky;
  logic [IDX_W-1:0] first_bad_idx;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  int m_match = 0;
  int m_mis   = 0;
  int m_tog   = 0;
  int m_err   = 0;
  int m_idx   = 0;
  int m_busy  = 0;
  int run     = 0;
  int p_cop   = 0;
  int p_ref   = 0;
  int pp_ref  = 0;

  broadcast_load_checker #(
    .NCOPY (NCOPY),
    .CNT_W (CNT_W),
    .SETTLE(SETTLE),
    .IDX_W (IDX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .ref_in       (ref_in),
    .copies       (copies),
    .match        (match),
    .mismatch_cnt (mismatch_cnt),
    .toggle_cnt   (toggle_cnt),
    .err_sticky   (err_sticky),
    .first_bad_idx(first_bad_idx),
    .busy         (busy)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  function automatic int lowestSet(input int v);
    for (int i = 0; i < NCOPY; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // This task counts one comparison and reports it when the two values differ.
  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // This task drives one cycle of inputs. It waits for the edge that samples
  // them and then settles 2 units past that edge, where the outputs are stable.
  task automatic applyStimulus(input bit r, input bit e, input bit c, input bit rf,
                               input logic [NCOPY-1:0] cp);
    rst    = r;
    en     = e;
    clr    = c;
    ref_in = rf;
    copies = cp;
    @(posedge clk);
    #2;
  endtask

  // The reference model updates on each rising edge. It reads inputs that the
  // stimulus set 2 units after the previous edge. A comparison takes effect
  // only with en high, after more than SETTLE consecutive enabled edges. The
  // data compared is the data sampled one edge earlier.
  always @(posedge clk) begin
    int bad;
    bit chk;
    if (rst) begin
      m_match = 0;
      m_mis   = 0;
      m_tog   = 0;
      m_err   = 0;
      m_idx   = 0;
      m_busy  = 0;
      run     = 0;
      p_cop   = 0;
      p_ref   = 0;
      pp_ref  = 0;
    end else begin
      bad = p_cop ^ (p_ref != 0 ? ALL : 0);
      chk = en && (run >= SETTLE + 1);
      m_match = (chk && bad == 0) ? 1 : 0;
      if (clr) begin
        m_mis = 0;
        m_tog = 0;
        m_err = 0;
        m_idx = 0;
      end else if (chk) begin
        if (bad != 0 && m_mis < CNT_MAX) m_mis++;
        if (bad != 0 && m_err == 0) begin
          m_err = 1;
          m_idx = lowestSet(bad);
        end
        if (p_ref != pp_ref && m_tog < CNT_MAX) m_tog++;
      end
      run    = en ? ((run < 1000) ? run + 1 : run) : 0;
      m_busy = en ? 1 : 0;
      pp_ref = p_ref;
      p_ref  = int'(ref_in);
      p_cop  = int'(copies);
    end
  end

  // The compare process checks every output against the model on each falling
  // edge, after the first reset has put the DUT in a known state.
  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("match",         int'(match),         m_match);
      checkOutput("mismatch_cnt",  int'(mismatch_cnt),  m_mis);
      checkOutput("toggle_cnt",    int'(toggle_cnt),    m_tog);
      checkOutput("err_sticky",    int'(err_sticky),    m_err);
      checkOutput("first_bad_idx", int'(first_bad_idx), m_idx);
      checkOutput("busy",          int'(busy),          m_busy);
    end
  end

  // Directed scenarios with literal expectations, followed by random traffic.
  initial begin
    bit r;
    bit e;
    bit c;
    bit rf;
    logic [NCOPY-1:0] cp;

    rst    = 1'b1;
    en     = 1'b0;
    clr    = 1'b0;
    ref_in = 1'b0;
    copies = '0;
    @(posedge clk);
    #2;
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    cmp_on = 1'b1;
    checkOutput("lit_reset_busy",  int'(busy), 0);
    checkOutput("lit_reset_match", int'(match), 0);
    checkOutput("lit_reset_mis",   int'(mismatch_cnt), 0);
    checkOutput("lit_reset_tog",   int'(toggle_cnt), 0);
    checkOutput("lit_reset_err",   int'(err_sticky), 0);
    checkOutput("lit_reset_idx",   int'(first_bad_idx), 0);

    // Enable, with the copies equal to ref and ref toggling every cycle.
    for (int k = 0; k < 10; k++) begin
      rf = (k % 2) != 0;
      applyStimulus(0, 1, 0, rf, {NCOPY{rf}});
      if (k == 0) checkOutput("lit_busy_after_en", int'(busy), 1);
      if (k == 2) checkOutput("lit_match_settling", int'(match), 0);
      if (k == 3) checkOutput("lit_match_third_edge", int'(match), 1);
    end
    checkOutput("lit_toggle_7", int'(toggle_cnt), 7);
    checkOutput("lit_clean_mis", int'(mismatch_cnt), 0);
    checkOutput("lit_clean_err", int'(err_sticky), 0);

    // First error at copy 1; a later error at copy 2 keeps the index.
    applyStimulus(0, 1, 0, 0, 4'b1010);
    applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("lit_err1_mis",   int'(mismatch_cnt), 1);
    checkOutput("lit_err1_err",   int'(err_sticky), 1);
    checkOutput("lit_err1_idx",   int'(first_bad_idx), 1);
    checkOutput("lit_err1_match", int'(match), 0);
    applyStimulus(0, 1, 0, 0, 4'b0100);
    applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("lit_err2_mis", int'(mismatch_cnt), 2);
    checkOutput("lit_err2_idx", int'(first_bad_idx), 1);
    applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("lit_rematch", int'(match), 1);

    // Dropping en: the FSM goes idle and the counters hold.
    applyStimulus(0, 0, 0, 0, 4'b0000);
    checkOutput("lit_drop_busy",  int'(busy), 0);
    checkOutput("lit_drop_match", int'(match), 0);
    checkOutput("lit_drop_mis",   int'(mismatch_cnt), 2);

    // Clear, then drive mismatches only during the settle window.
    applyStimulus(0, 0, 1, 0, 4'b0000);
    checkOutput("lit_clr_mis", int'(mismatch_cnt), 0);
    checkOutput("lit_clr_err", int'(err_sticky), 0);
    applyStimulus(0, 1, 0, 0, 4'b1111);
    applyStimulus(0, 1, 0, 0, 4'b1111);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("lit_settle_mis",   int'(mismatch_cnt), 0);
    checkOutput("lit_settle_err",   int'(err_sticky), 0);
    checkOutput("lit_settle_match", int'(match), 1);

    // clr in the same cycle as a mismatch, then a fresh error at copy 3.
    applyStimulus(0, 1, 0, 0, 4'b1111);
    applyStimulus(0, 1, 1, 0, 4'b0000);
    checkOutput("lit_clrwin_mis",   int'(mismatch_cnt), 0);
    checkOutput("lit_clrwin_err",   int'(err_sticky), 0);
    checkOutput("lit_clrwin_match", int'(match), 0);
    applyStimulus(0, 1, 0, 0, 4'b1000);
    applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("lit_fresh_mis", int'(mismatch_cnt), 1);
    checkOutput("lit_fresh_idx", int'(first_bad_idx), 3);

    // Continuous mismatch with ref toggling: both counters saturate.
    for (int k = 0; k < 300; k++) begin
      rf = (k % 2) != 0;
      applyStimulus(0, 1, 0, rf, {NCOPY{~rf}});
    end
    checkOutput("lit_sat_mis", int'(mismatch_cnt), CNT_MAX);
    checkOutput("lit_sat_tog", int'(toggle_cnt), CNT_MAX);
    applyStimulus(0, 1, 0, 0, 4'b1111);
    checkOutput("lit_sat_hold", int'(mismatch_cnt), CNT_MAX);

    // Reset mid-check overrides en and clr.
    applyStimulus(1, 1, 1, 1, 4'b1111);
    checkOutput("lit_rst_busy",  int'(busy), 0);
    checkOutput("lit_rst_mis",   int'(mismatch_cnt), 0);
    checkOutput("lit_rst_tog",   int'(toggle_cnt), 0);
    checkOutput("lit_rst_err",   int'(err_sticky), 0);
    checkOutput("lit_rst_match", int'(match), 0);

    // Randomized traffic with occasional faults, clears and resets.
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 99) < 92);
      c  = ($urandom_range(0, 99) < 3);
      rf = ($urandom_range(0, 1) != 0);
      cp = {NCOPY{rf}};
      if ($urandom_range(0, 3) == 0) cp = cp ^ NCOPY'($urandom_range(1, ALL));
      applyStimulus(r, e, c, rf, cp);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
